instr_fetch_unit: RTL

Front-end stage upstream of the instruction memory. Owns the program counter, drives the combinational instruction-memory address, and captures each returned word with its PC into a small in-order fetch queue. The queue presents instructions to decode through a valid/ready handshake. Branch/jump redirects flush all queued words and restart fetch at the target.

---
 rtl/fetch_pkg.sv | 21 ++
 rtl/fetch_queue.sv | 86 ++++++++
 rtl/instr_fetch_unit.sv | 91 +++++++++
 3 files changed

// File: rtl/fetch_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fetch_pkg
// Description : Shared types and constants for the instruction-fetch front
//               end: datapath width, default reset PC, canonical NOP and the
//               packed fetch-queue entry {pc, instr}.
// Revision    : 1.0 - initial release
// ============================================================================
package fetch_pkg;

  localparam int          XLEN             = 32;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam logic [31:0] INSTR_NOP        = 32'h0000_0013;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } fetch_entry_t;

endpackage : fetch_pkg
`default_nettype wire

// File: rtl/fetch_queue.sv
`default_nettype none
// ============================================================================
// Module      : fetch_queue
// Description : In-order FIFO of DEPTH fetch entries. The head entry is kept
//               in a dedicated register so the outputs are defined out of
//               reset (storage itself is not reset) and hold their last value
//               when the queue drains.
// Ports       : clk    - clock, rising edge
//               rst_n  - asynchronous active-low reset
//               push   - write wdata at tail (caller guarantees room)
//               pop    - retire head (caller guarantees non-empty)
//               flush  - discard all entries; overrides push/pop
//               wdata  - entry to write
//               count  - number of valid entries (0..DEPTH)
//               head   - oldest entry
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     flush,
  input  fetch_entry_t             wdata,
  output logic [$clog2(DEPTH):0]   count,
  output fetch_entry_t             head
);

  localparam int c_ptr_w = $clog2(DEPTH);
  localparam int c_cnt_w = c_ptr_w + 1;

  fetch_entry_t             r_mem [DEPTH];
  fetch_entry_t             r_head;
  logic [c_ptr_w-1:0]       r_rd_ptr;
  logic [c_ptr_w-1:0]       r_wr_ptr;
  logic [c_cnt_w-1:0]       r_count;

  logic [c_ptr_w-1:0]       w_rd_next;
  logic [c_cnt_w-1:0]       w_cnt_after_pop;
  logic [c_cnt_w-1:0]       w_count_next;
  fetch_entry_t             w_head_next;

  assign w_rd_next       = r_rd_ptr + c_ptr_w'(pop);
  assign w_cnt_after_pop = r_count - c_cnt_w'(pop);
  assign w_count_next    = w_cnt_after_pop + c_cnt_w'(push);

  // If nothing older survives the pop, the word being pushed becomes the
  // head directly (bypass); otherwise the next stored entry moves up.
  assign w_head_next = (w_cnt_after_pop == '0) ? wdata : r_mem[w_rd_next];

  always_ff @(posedge clk) begin
    if (push && !flush) begin
      r_mem[r_wr_ptr] <= wdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
      r_head   <= '0;
    end else if (flush) begin
      // Head register keeps its stale value; it is only observed when valid.
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      r_rd_ptr <= w_rd_next;
      r_wr_ptr <= r_wr_ptr + c_ptr_w'(push);
      r_count  <= w_count_next;
      if (w_count_next != '0) begin
        r_head <= w_head_next;
      end
    end
  end

  assign count = r_count;
  assign head  = r_head;

endmodule : fetch_queue
`default_nettype wire

// File: rtl/instr_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : instr_fetch_unit
// Description : Fetch front end. Owns the PC, addresses instruction memory
//               (combinational read), and queues {instr, pc} pairs for decode
//               through a valid/ready handshake. Redirect flushes the queue
//               and restarts fetch at the word-aligned target.
// Ports       : CLK          - clock, rising edge
//               RST          - asynchronous active-low reset
//               Fetch_En     - 0 freezes PC and pushes (pops continue)
//               IMEM_A       - instruction address (PC register)
//               IMEM_RD      - instruction word for IMEM_A, same cycle
//               Redirect     - control-flow change, highest priority
//               Redirect_PC  - redirect target, bits [1:0] ignored
//               Out_Valid    - head of queue is valid
//               Out_Ready    - decode accepts head
//               Out_Instr    - head instruction
//               Out_PC       - head instruction address
//               Out_PCPlus4  - Out_PC + 4 (mod 2^32)
// Revision    : 1.0 - initial release
// ============================================================================
module instr_fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
  parameter int          DEPTH    = 2
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic            Fetch_En,
  output logic [XLEN-1:0] IMEM_A,
  input  logic [XLEN-1:0] IMEM_RD,
  input  logic            Redirect,
  input  logic [XLEN-1:0] Redirect_PC,
  output logic            Out_Valid,
  input  logic            Out_Ready,
  output logic [XLEN-1:0] Out_Instr,
  output logic [XLEN-1:0] Out_PC,
  output logic [XLEN-1:0] Out_PCPlus4
);

  localparam int                 c_cnt_w = $clog2(DEPTH) + 1;
  localparam logic [c_cnt_w-1:0] c_depth = c_cnt_w'(DEPTH);

  logic [XLEN-1:0]    r_pc;
  logic [c_cnt_w-1:0] w_count;
  fetch_entry_t       w_head;
  fetch_entry_t       w_wdata;
  logic               w_pop;
  logic               w_push;

  assign Out_Valid = (w_count != '0);

  // A handshake during a redirect is not an acceptance: the flush wins.
  assign w_pop  = Out_Valid & Out_Ready & ~Redirect;
  // Full queue may still accept a word when the head leaves this cycle.
  assign w_push = Fetch_En & ~Redirect & ((w_count < c_depth) | w_pop);

  assign w_wdata.pc    = r_pc;
  assign w_wdata.instr = IMEM_RD;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_pc <= RESET_PC;
    end else if (Redirect) begin
      r_pc <= {Redirect_PC[XLEN-1:2], 2'b00};
    end else if (w_push) begin
      r_pc <= r_pc + 32'd4;
    end
  end

  fetch_queue #(
    .DEPTH (DEPTH)
  ) u_queue (
    .clk   (CLK),
    .rst_n (RST),
    .push  (w_push),
    .pop   (w_pop),
    .flush (Redirect),
    .wdata (w_wdata),
    .count (w_count),
    .head  (w_head)
  );

  assign IMEM_A      = r_pc;
  assign Out_Instr   = w_head.instr;
  assign Out_PC      = w_head.pc;
  assign Out_PCPlus4 = w_head.pc + 32'd4;

endmodule : instr_fetch_unit
`default_nettype wire
